// File: rtl/mult_shift_add.sv
// ----------------------------------------------------------------------------
// mult_shift_add
//   Sequential unsigned shift-and-add multiplier. It takes one iteration per
//   multiplier bit and uses an external adder for each partial-sum addition.
//   The file also holds cla32, a 32-bit carry-lookahead adder that is meant to
//   be wired to the add_* ports.
//
// Ports (mult_shift_add):
//   clk           single clock, rising-edge active
//   rst_n         asynchronous active-low reset
//   start         request a multiply; sampled only while idle
//   multiplicand  unsigned operand A (WIDTH bits)
//   multiplier    unsigned operand B (WIDTH bits)
//   busy          high while iterating
//   done          one-cycle pulse; product is valid
//   product       registered 2*WIDTH-bit product
//   add_a/add_b   operands sent to the external adder (0 outside iteration)
//   add_cin       adder carry-in, tied to 0
//   add_sum       adder sum, combinational from add_a/add_b/add_cin
//   add_cout      adder carry-out
// ----------------------------------------------------------------------------
module mult_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mcand_r;
    logic [CW-1:0]      count;

    // The upper half of acc is the running partial sum. The lower half starts
    // as the multiplier and is shifted out one bit per iteration. Its LSB
    // selects whether the multiplicand is added this round.
    assign add_a   = (state == CALC) ? acc[2*WIDTH-1:WIDTH] : '0;
    assign add_b   = ((state == CALC) && acc[0]) ? mcand_r : '0;
    assign add_cin = 1'b0;

    // The adder result is WIDTH+1 bits wide including carry-out. Shifting it
    // right as one word keeps the full product without truncation.
    assign acc_next = {add_cout, add_sum, acc[WIDTH-1:1]};

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // State register. Reset forces the machine back to idle immediately, which
    // aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. start only matters in IDLE. DONE always lasts exactly
    // one cycle, so a start that is held high restarts after a pass through IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (count == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers. Operands are captured when a start is accepted, so
    // later changes on the inputs cannot disturb the iteration. product is
    // loaded only on the final iteration. It then holds across later starts
    // until the next result arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand_r <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_r <= multiplicand;
                        acc     <= {{WIDTH{1'b0}}, multiplier};
                        count   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        product <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// ----------------------------------------------------------------------------
// cla32
//   32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
//   The group carries ripple from one group to the next.
//
// Ports:
//   a, b   32-bit addends
//   cin    carry-in
//   sum    32-bit sum
//   cout   carry-out of bit 31
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
// ----------------------------------------------------------------------------
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        ovf
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    // Each group works out all of its internal carries and its carry-out
    // directly from generate/propagate and the group carry-in. No carry ripples
    // bit by bit inside a group.
    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
    assign ovf  = c[32] ^ c[31];

endmodule

// File: tb/tb_mult_shift_add.sv
// ----------------------------------------------------------------------------
// tb_mult_shift_add
//   Directed testbench for mult_shift_add connected to a cla32 adder. It runs
//   hand-computed products, ignores a start issued mid-operation, checks the
//   back-to-back period with start held high, and checks an asynchronous abort.
// ----------------------------------------------------------------------------
module tb_mult_shift_add;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        add_ovf;

    int assertCount = 0;
    int failCount   = 0;

    mult_shift_add #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_sum      (add_sum),
        .add_cout     (add_cout)
    );

    cla32 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. Every check goes through here and is counted.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one complete multiply with a single-cycle start pulse. Checks the
    // first iteration's adder operands, the product held from the previous
    // run, the busy length, the result on done, and the return to idle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] exp, input string tag);
        logic [63:0] prev;
        int          cycles;
        prev         = product;
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        step();
        start = 1'b0;
        checkOutput({tag, "_busy_start"}, 64'(busy), 64'd1);
        checkOutput({tag, "_hold_prev"}, product, prev);
        checkOutput({tag, "_add_a0"}, 64'(add_a), 64'd0);
        checkOutput({tag, "_add_b0"}, 64'(add_b), b[0] ? 64'(a) : 64'd0);
        cycles = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            cycles++;
            step();
        end
        checkOutput({tag, "_busy_len"}, 64'(cycles), 64'd32);
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_product"}, product, exp);
        step();
        checkOutput({tag, "_done_clr"}, 64'(done), 64'd0);
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Directed sequence, one step after another.
    initial begin
        int doneCount;
        int busyRise;
        int gap;
        logic busyPrev;

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        $display("[TB] reset");
        repeat (3) step();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_product", product, 64'd0);
        checkOutput("rst_add_a", 64'(add_a), 64'd0);
        checkOutput("rst_add_b", 64'(add_b), 64'd0);
        checkOutput("rst_add_cin", 64'(add_cin), 64'd0);
        rst_n = 1'b1;
        step();

        $display("[TB] basic products");
        applyStimulus(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5");
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
        applyStimulus(32'h7654_3210, 32'd0, 64'd0, "b_zero");
        applyStimulus(32'h8765_4321, 32'd1, 64'h0000_0000_8765_4321, "b_one");
        applyStimulus(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "carry_hi");

        $display("[TB] start during CALC ignored");
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        start        = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
        step();
        start     = 1'b0;
        doneCount = 0;
        busyRise  = 0;
        busyPrev  = busy;
        for (int i = 0; i < 60; i++) begin
            if (done) doneCount++;
            if (busy && !busyPrev) busyRise++;
            busyPrev = busy;
            step();
        end
        checkOutput("ign_product", product, 64'd63);
        checkOutput("ign_done_cnt", 64'(doneCount), 64'd1);
        checkOutput("ign_busy_rise", 64'(busyRise), 64'd0);

        $display("[TB] start held high");
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        start        = 1'b1;
        for (int i = 0; i < 40 && !done; i++) step();
        checkOutput("held_done1", 64'(done), 64'd1);
        checkOutput("held_product", product, 64'd25);
        gap = 0;
        step();
        gap++;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            gap++;
        end
        checkOutput("held_period", 64'(gap), 64'd34);
        start = 1'b0;
        repeat (2) step();
        checkOutput("held_stop", 64'(busy), 64'd0);

        $display("[TB] async abort");
        multiplicand = 32'hFFFF_FFFF;
        multiplier   = 32'd2;
        start        = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        checkOutput("abort_pre_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_product", product, 64'd0);
        checkOutput("abort_add_b", 64'(add_b), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        applyStimulus(32'd6, 32'd7, 64'd42, "post_rst");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mult_shift_add.md
MULT_SHIFT_ADD -- requirements
Module: mult_shift_add

Interface
REQ-001 Parameter WIDTH, default 32, operand width; product is 2*WIDTH; add port widths track WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 multiplicand  input  32  unsigned operand A.
REQ-006 multiplier  input  32  unsigned operand B.
REQ-007 busy  output  1  high while iterating (CALC).
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  64  unsigned A*B, registered.
REQ-010 add_a  output  32  operand A to external cla32 adder.
REQ-011 add_b  output  32  operand B to external cla32 adder.
REQ-012 add_cin  output  1  carry-in to adder, constant 0.
REQ-013 add_sum  input  32  adder sum, combinational from add_a/add_b/add_cin.
REQ-014 add_cout  input  1  adder carry-out; adder overflow output unused by this block.

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE -> CALC on start=1; CALC -> DONE after 32nd iteration; DONE -> IDLE unconditionally next edge.
REQ-016 Start edge E0 (IDLE, start=1): capture multiplicand into mcand_r, multiplier into low half of acc (acc[31:0]), clear acc[63:32], clear count.
REQ-017 CALC edges E1..E32: one iteration each; count increments 0..31; exit to DONE on edge where count=31.
REQ-018 Per iteration: add_a = acc[63:32]; add_b = mcand_r if acc[0]=1, else 0; add_cin = 0.
REQ-019 Per iteration update: acc <= {add_cout, add_sum, acc[31:1]} (33-bit add result concatenated, shift right by one).
REQ-020 Outside CALC, add_a and add_b drive 0.
REQ-021 product register loads acc-next on edge E32; holds value until next E32; not cleared by a new start.
REQ-022 busy = 1 exactly in CALC (32 cycles); done = 1 exactly in DONE (one cycle, after E32, cleared after E33).
REQ-023 Latency: done high in cycle following E32, i.e. 33 edges after start sampled; next start accepted earliest at E34 (IDLE).
REQ-024 start ignored in CALC and DONE; operands changing during CALC have no effect.
REQ-025 start held high continuously: new operation begins every 34 cycles (IDLE re-entry each time).
REQ-026 Arithmetic unsigned, no truncation; full 64-bit result; adder overflow ignored.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, busy 0, done 0, product 0, acc 0, mcand_r 0, count 0, add_a 0, add_b 0, add_cin 0.
REQ-028 Reset mid-CALC or in DONE aborts operation; no done pulse; product reads 0.
REQ-029 After rst_n deasserts, first start is accepted on first rising edge with start=1.

Verification
REQ-030 Bench instantiates mult_shift_add wired to a cla32 instance.
REQ-031 A=3, B=5, start one cycle -> busy 32 cycles, done pulse, product=0x0000_0000_0000_000F.
REQ-032 A=0xFFFFFFFF, B=0xFFFFFFFF -> product=0xFFFF_FFFE_0000_0001.
REQ-033 A=0x76543210, B=0 -> product=0; A=0x87654321, B=1 -> product=0x0000_0000_8765_4321.
REQ-034 start pulsed with A=2, B=2 at CALC cycle 10 of a 7x9 operation -> product=63, only one done pulse, no second busy period.
REQ-035 rst_n low at CALC cycle 16 of 0xFFFFFFFF*2 -> busy/done/product 0 immediately; next start A=6, B=7 -> product=42.
